// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clk_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int MIN_DIV = 2;

    // High phase length for ratio n; odd ratios put the extra cycle in the low phase.
    function automatic logic [31:0] half_phase(input logic [31:0] n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/clk_div_cfg_shadow.sv
// Ratio write path: legality check, error pulse and the shadow ratio that
// waits for the next period boundary while the divider is running.
module clk_div_cfg_shadow
    import clk_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_wr,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic             run,
    input  logic             apply,
    output logic             legal_wr,
    output logic [WIDTH-1:0] shadow,
    output logic             cfg_pending,
    output logic             cfg_err
);

    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             err_q, err_d;

    always_comb begin
        legal_wr  = cfg_wr && (32'(cfg_div) >= MIN_DIV);
        err_d     = cfg_wr && !legal_wr;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (apply) begin
            pending_d = 1'b0;
        end
        // A write landing on a boundary cycle is queued behind the value applied there.
        if (legal_wr) begin
            if (run) begin
                shadow_d  = cfg_div;
                pending_d = 1'b1;
            end else begin
                pending_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign shadow      = shadow_q;
    assign cfg_pending = pending_q;
    assign cfg_err     = err_q;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with glitch-free ratio changes,
// graceful stop on en deassertion and a period-start tick.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_wr,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_pending,
    output logic             cfg_err,
    output logic [WIDTH-1:0] div_active,
    output logic             clk_out,
    output logic             tick,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_active_q, div_active_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;

    logic [WIDTH-1:0] cnt_inc;
    logic             boundary;
    logic             apply;
    logic             legal_wr;
    logic [WIDTH-1:0] shadow;
    logic             pending;

    clk_div_cfg_shadow #(
        .WIDTH(WIDTH)
    ) u_cfg (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_wr     (cfg_wr),
        .cfg_div    (cfg_div),
        .run        (state_q == RUN),
        .apply      (apply),
        .legal_wr   (legal_wr),
        .shadow     (shadow),
        .cfg_pending(pending),
        .cfg_err    (cfg_err)
    );

    // Compare-and-wrap keeps ratios up to 2**WIDTH-1 free of counter rollover.
    always_comb begin
        cnt_inc  = (cnt_q == div_active_q - WIDTH'(1)) ? '0 : cnt_q + WIDTH'(1);
        boundary = (state_q == RUN) && (cnt_inc == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            div_active_q <= WIDTH'(DEFAULT_DIV);
            clk_out_q    <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_active_q <= div_active_d;
            clk_out_q    <= clk_out_d;
            tick_q       <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (boundary && !en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        clk_out_d    = clk_out_q;
        tick_d       = 1'b0;
        div_active_d = div_active_q;
        apply        = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                clk_out_d = en;
                tick_d    = en;
                apply     = en;
            end
            RUN: begin
                cnt_d = cnt_inc;
                if (boundary) begin
                    apply     = 1'b1;
                    clk_out_d = en;
                    tick_d    = en;
                end else begin
                    clk_out_d = 32'(cnt_inc) < half_phase(32'(div_active_q));
                end
            end
            default: begin
                cnt_d     = '0;
                clk_out_d = 1'b0;
            end
        endcase
        // Shadow is applied only on a new period; an IDLE write takes effect at once.
        if (apply && pending) begin
            div_active_d = shadow;
        end
        if (legal_wr && state_q == IDLE) begin
            div_active_d = cfg_div;
        end
    end

    always_comb begin
        busy = (state_q == RUN);
    end

    assign cfg_pending = pending;
    assign div_active  = div_active_q;
    assign clk_out     = clk_out_q;
    assign tick        = tick_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: a countdown-style reference model pushes
// the expected post-edge outputs, which are popped and compared after each edge.
module tb_clk_div_prog;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       cfg_wr;
    logic [7:0] cfg_div;
    logic       cfg_pending;
    logic       cfg_err;
    logic [7:0] div_active;
    logic       clk_out;
    logic       tick;
    logic       busy;

    clk_div_prog #(
        .WIDTH      (8),
        .DEFAULT_DIV(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cfg_wr     (cfg_wr),
        .cfg_div    (cfg_div),
        .cfg_pending(cfg_pending),
        .cfg_err    (cfg_err),
        .div_active (div_active),
        .clk_out    (clk_out),
        .tick       (tick),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       clk_out;
        logic       tick;
        logic       busy;
        logic       pending;
        logic       err;
        logic [7:0] div;
    } exp_t;

    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: m_left counts cycles remaining in the current period.
    logic       m_run;
    int         m_left;
    int         m_n;
    int         m_shadow;
    logic       m_pend;
    logic       m_clk;
    logic       m_tick;
    logic       m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_left = 0; m_n = 8; m_shadow = 0;
        m_pend = 1'b0; m_clk = 1'b0; m_tick = 1'b0; m_err = 1'b0;
    endtask

    function automatic int elapsed();
        return m_n - 1 - m_left;
    endfunction

    task automatic model_edge(input logic e, input logic wr, input int div);
        logic legal;
        int   n_new;
        legal = wr && (div >= 2);
        m_err = wr && (div < 2);
        if (!m_run) begin
            if (e) begin
                n_new  = legal ? div : (m_pend ? m_shadow : m_n);
                m_n    = n_new;
                m_pend = 1'b0;
                m_run  = 1'b1;
                m_left = n_new - 1;
                m_clk  = 1'b1;
                m_tick = 1'b1;
            end else begin
                if (legal) begin
                    m_n    = div;
                    m_pend = 1'b0;
                end
                m_clk  = 1'b0;
                m_tick = 1'b0;
            end
        end else if (m_left == 0) begin
            n_new  = m_pend ? m_shadow : m_n;
            m_n    = n_new;
            m_pend = 1'b0;
            if (legal) begin
                m_shadow = div;
                m_pend   = 1'b1;
            end
            if (e) begin
                m_left = n_new - 1;
                m_clk  = 1'b1;
                m_tick = 1'b1;
            end else begin
                m_run  = 1'b0;
                m_clk  = 1'b0;
                m_tick = 1'b0;
            end
        end else begin
            m_left = m_left - 1;
            m_clk  = ((m_n - 1 - m_left) < (m_n / 2));
            m_tick = 1'b0;
            if (legal) begin
                m_shadow = div;
                m_pend   = 1'b1;
            end
        end
    endtask

    task automatic step();
        exp_t e;
        model_edge(en, cfg_wr, int'(cfg_div));
        e.clk_out = m_clk;
        e.tick    = m_tick;
        e.busy    = m_run;
        e.pending = m_pend;
        e.err     = m_err;
        e.div     = 8'(m_n);
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = sb.pop_front();
        check("clk_out", 32'(clk_out), 32'(e.clk_out));
        check("tick", 32'(tick), 32'(e.tick));
        check("busy", 32'(busy), 32'(e.busy));
        check("cfg_pending", 32'(cfg_pending), 32'(e.pending));
        check("cfg_err", 32'(cfg_err), 32'(e.err));
        check("div_active", 32'(div_active), 32'(e.div));
        cfg_wr = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write(input int div);
        cfg_wr  = 1'b1;
        cfg_div = 8'(div);
        step();
    endtask

    // Advance until the model is running ratio n and sits at cnt == el.
    task automatic wait_pos(input int n, input int el);
        int budget = 700;
        while (!(m_run && m_n == n && elapsed() == el) && budget > 0) begin
            step();
            budget--;
        end
        check("wait_div_active", 32'(div_active), 32'(n));
    endtask

    initial begin
        model_reset();
        rst_n   = 1'b0;
        en      = 1'b0;
        cfg_wr  = 1'b0;
        cfg_div = 8'd0;
        #23;
        check("rst_clk_out", 32'(clk_out), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pending", 32'(cfg_pending), 32'd0);
        check("rst_err", 32'(cfg_err), 32'd0);
        check("rst_div_active", 32'(div_active), 32'd8);

        // Default ratio 8: 4 high / 4 low from the first edge after release.
        en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        run(26);

        // Mid-period change to 5 waits for the boundary.
        wait_pos(8, 2);
        write(5);
        run(22);

        // Illegal ratios 0 and 1 are rejected.
        write(0);
        run(3);
        write(1);
        run(8);

        // Switch to 6, then drop en at cnt=1 and restart with a same-cycle write of 7.
        write(6);
        wait_pos(6, 1);
        en = 1'b0;
        run(10);
        en = 1'b1;
        write(7);
        run(10);

        // 3 then 7 in one period, 4 on the boundary cycle itself.
        wait_pos(7, 1);
        write(3);
        write(7);
        while (m_left != 0) step();
        write(4);
        run(20);

        // Async reset in the high phase of a 255 period.
        write(255);
        wait_pos(255, 10);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_clk_out", 32'(clk_out), 32'd0);
        check("arst_tick", 32'(tick), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_div_active", 32'(div_active), 32'd8);
        check("arst_pending", 32'(cfg_pending), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Runtime-programmable integer clock divider. Successor to the fixed divide-by-8 divider.
- Adds:
  - WIDTH-bit divide ratio, changed glitch-free at period boundaries.
  - Enable with graceful stop.
  - Period-start tick pulse.
  - Async active-low reset.
  - Illegal-ratio detection.
- Feeds the scrambler datapath and any logic needing a slow strobe or derived clock from the system clock.

Parameters:
- WIDTH, 8, width of divide ratio and internal counter.
- DEFAULT_DIV, 8, active ratio after reset. Must be >= 2 and < 2**WIDTH.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run request; sampled every cycle.
- cfg_wr  in  1  single-cycle write strobe for cfg_div.
- cfg_div  in  WIDTH  requested divide ratio N.
- cfg_pending  out  1  a legal ratio is stored but not yet applied.
- cfg_err  out  1  one-cycle pulse: the write was rejected (cfg_div < 2).
- div_active  out  WIDTH  ratio currently in effect.
- clk_out  out  1  registered divided clock.
- tick  out  1  one-cycle pulse coincident with each clk_out rising edge.
- busy  out  1  high while in RUN.

Behaviour:
- Reset (async assert, sync release effect):
  - state=IDLE, cnt=0, clk_out=0, tick=0.
  - cfg_pending=0, cfg_err=0, shadow=0, div_active=DEFAULT_DIV, busy=0.
- Phases for active ratio N:
  - High phase H = N>>1 cycles; low phase L = N-H.
  - Period is N clk cycles. Odd N gives a low phase one cycle longer, e.g. N=5 → 2 high, 3 low.
- State IDLE:
  - clk_out=0, cnt=0.
  - If en=1 at an edge: next state RUN, cnt<=0, clk_out<=1, tick<=1.
- State RUN:
  - Each edge: cnt_next = (cnt==N-1) ? 0 : cnt+1.
  - If cnt_next!=0: clk_out <= (cnt_next < H), tick<=0.
  - If cnt_next==0 (boundary):
    - If cfg_pending, apply shadow first: div_active<=shadow, cfg_pending<=0. The new N governs the period starting now.
    - If en=1: clk_out<=1, tick<=1, stay in RUN.
    - If en=0: clk_out<=0, tick<=0, go to IDLE.
  - en deassertion mid-period never truncates the period. No runt pulses.
- Config writes:
  - Illegal write (cfg_wr=1, cfg_div<2): cfg_err<=1 for one cycle. Shadow, pending and div_active are unchanged.
  - Legal write in IDLE: div_active<=cfg_div next edge; cfg_pending stays 0.
  - Legal write in RUN: shadow<=cfg_div, cfg_pending<=1.
  - Last write wins if several land before a boundary.
  - A legal write in the same cycle as a boundary is not applied at that boundary. The previous shadow, if any, is applied; the new value becomes pending for the next boundary.
  - A legal write in the same cycle as the IDLE→RUN transition: the new ratio is used from the first period.
- Latency:
  - en=1 in IDLE → clk_out high 1 cycle later.
  - tick is aligned with the clk_out 0→1 register update.
- Width: cnt is WIDTH bits. N up to 2**WIDTH-1 with no overflow; compare-and-wrap, never natural rollover.
- Reset mid-period: outputs drop immediately (async). Operation resumes from IDLE.
- clk_out is a registered signal. Downstream logic uses tick as an enable; clk_out drives clock pins only via a clock buffer.

Decomposition:
- Package clk_div_pkg:
  - state enum {IDLE, RUN}.
  - MIN_DIV=2.
  - function half_phase(N) returning N>>1.
- One natural sub-module, clk_div_cfg_shadow. It holds shadow, cfg_pending, cfg_err and the legality check. It takes an apply strobe from the counter FSM. Counter/FSM stay in the top.

Test Plan:
- Reset with en=1, default N=8 → first clk_out rise 1 cycle after reset release. Pattern 4 high / 4 low repeating; tick every 8 cycles; busy=1.
- Legal write cfg_div=5 mid-period at N=8 → cfg_pending=1 until the boundary. The current 8-cycle period completes, then 2 high / 3 low. div_active changes from 8 to 5 at the boundary.
- Illegal writes cfg_div=0 and then cfg_div=1 → one cfg_err pulse each. div_active and waveform are unchanged; cfg_pending stays 0.
- en dropped at cnt=1 (N=6) → clk_out completes 3 high / 3 low, then stays 0 in IDLE with no tick. Re-assert en → clk_out high next cycle.
- Writes 3 then 7 in the same period, then a write of 4 exactly on the boundary cycle → 7 is applied at that boundary and 4 at the next boundary.
- rst_n pulsed low mid high phase (N=255, WIDTH=8) → clk_out, tick and busy drop asynchronously. After release: div_active=8, IDLE→RUN, 4/4 pattern.
